mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter sharing the SoC's single-port memory between the CPU instruction-fetch port and data load/store port. Sits between `cpu` and the memory in `soc`. Accepts one transaction at a time, drives the memory for a fixed read latency, and returns read data to the owning requester. Grants alternate between requesters under contention, so neither can starve.

## Interface
- `ADDR_WIDTH`, default 32: byte-address width.
- `DATA_WIDTH`, default 32: data width; `DATA_WIDTH/8` strobe bits.
- `MEM_LATENCY`, default 1: cycles from issue to valid `mem_rdata`; legal range ≥1.

- `clk`  in  1  single clock; all state changes on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `i_req`  in  1  fetch request (read-only port).
- `i_addr`  in  ADDR_WIDTH  fetch address.
- `i_ready`  out  1  fetch request accepted this cycle.
- `i_rvalid`  out  1  fetch read data valid, 1-cycle pulse.
- `i_rdata`  out  DATA_WIDTH  fetch read data.
- `d_req`  in  1  data request.
- `d_we`  in  1  1 = write, 0 = read.
- `d_addr`  in  ADDR_WIDTH  data address.
- `d_wdata`  in  DATA_WIDTH  write data.
- `d_wstrb`  in  DATA_WIDTH/8  byte write enables.
- `d_ready`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  data read data valid, 1-cycle pulse (reads only).
- `d_rdata`  out  DATA_WIDTH  data read data.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_WIDTH  memory address.
- `mem_wdata`  out  DATA_WIDTH  memory write data.
- `mem_wstrb`  out  DATA_WIDTH/8  memory byte enables.
- `mem_rdata`  in  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after issue.

## Operation
- States: IDLE, WAIT. Registers: `state`, `owner` (0 = data, 1 = fetch), `prio` (0 = data first, 1 = fetch first), `cnt` ($clog2(MEM_LATENCY+1) bits).
- IDLE: grant decided combinationally from current `i_req`/`d_req`. Only one requesting → grant it. Both → grant the one indicated by `prio`.
- Grant cycle: winner's `*_ready`=1; `mem_en`=1; `mem_addr`/`mem_we`/`mem_wdata`/`mem_wstrb` from winner (fetch: `mem_we`=0, `mem_wstrb`=0, `mem_wdata`=0). Loser's `*_ready`=0; loser holds request.
- On any grant, `prio` ← the non-granted port (alternation applies even without contention).
- Write grant: stays IDLE; write done in grant cycle; no rvalid. `d_wstrb`=0 is still issued.
- Read grant: `owner` ← winner, `cnt` ← MEM_LATENCY, state ← WAIT.
- WAIT: all `*_ready`=0, `mem_en`=0; `cnt` decrements each cycle. At `cnt`==1: owner's `*_rvalid`=1, `*_rdata`=`mem_rdata`; state ← IDLE next edge.
- `i_rdata`/`d_rdata` equal `mem_rdata` every cycle; valid only with the matching rvalid.
- Requesters hold `*_req` and fields stable until `*_ready`. Dropping `*_req` earlier withdraws the request with no side effect.
- Not in reset: outputs `mem_addr`/`mem_wdata`/`mem_wstrb` are 0 when `mem_en`=0.

## Timing
- Reset (`reset_n`=0 at edge): state=IDLE, `prio`=0, `owner`=0, `cnt`=0. While `reset_n`=0, all `*_ready`, `*_rvalid`, `mem_en`, `mem_we` forced 0 combinationally.
- Reset during WAIT abandons the in-flight read; no rvalid is ever produced for it.
- Read accepted at cycle T: rvalid at T+MEM_LATENCY; next grant earliest at T+MEM_LATENCY+1. Read throughput is 1 per MEM_LATENCY+1 cycles.
- Writes: 1 per cycle back-to-back.
- No grant is possible in the rvalid cycle itself.
- Under continuous contention, grants strictly alternate data, fetch, data, …

## Test plan
- MEM_LATENCY=2, fetch read only, `i_addr`=0x10, memory word 0x00200293 → `i_ready` at T, `mem_en`/`mem_addr`=0x10 at T, `i_rvalid` with `i_rdata`=0x00200293 at T+2, `d_rvalid` never.
- Data write 0x100 ← 0xDEADBEEF, `d_wstrb`=0xF, then data read 0x100 next cycle → write at T, read accepted T+1, `d_rdata`=0xDEADBEEF at T+3.
- Both `i_req` and `d_req` held out of reset, all reads → grants data, fetch, data, fetch; each 3 cycles apart; each rvalid goes only to the owner.
- Partial write `d_wstrb`=0x3 of 0xAAAA5555 over 0x11111111 → readback 0x11115555; `mem_wstrb`=0x3 in grant cycle.
- `reset_n` low for 1 cycle during WAIT of a fetch read → no `i_rvalid`; next cycle IDLE; simultaneous requests then grant data first.
- Fetch `i_req` pulsed one cycle while WAIT busy, then dropped → no grant, no memory access for it.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares one single-port memory between the instruction-fetch port
//            and the data load/store port. It handles one transaction at a
//            time. Grants alternate between the ports, so neither port starves.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  // instruction-fetch port (read-only)
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    i_ready,
  output logic                    i_rvalid,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  // data load/store port
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  output logic                    d_ready,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  // shared memory
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int c_CNT_W = $clog2(MEM_LATENCY + 1);
  localparam int c_STRB_W = DATA_WIDTH / 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t               r_state;
  logic                 r_owner;   // 0 = data, 1 = fetch
  logic                 r_prio;    // 0 = data first, 1 = fetch first
  logic [c_CNT_W-1:0]   r_cnt;

  logic w_idle;
  logic w_grant_d;
  logic w_grant_i;
  logic w_last;

  // Arbitration decision: only in IDLE and never while reset is asserted.
  always_comb begin
    w_idle    = (r_state == ST_IDLE) && reset_n;
    w_grant_d = w_idle && d_req && (!i_req || !r_prio);
    w_grant_i = w_idle && i_req && (!d_req ||  r_prio);
    w_last    = (r_state == ST_WAIT) && (r_cnt == c_CNT_W'(1)) && reset_n;
  end

  // Handshakes and read-return strobes for both requesters.
  always_comb begin
    d_ready  = w_grant_d;
    i_ready  = w_grant_i;
    i_rvalid = w_last &&  r_owner;
    d_rvalid = w_last && !r_owner;
    i_rdata  = mem_rdata;
    d_rdata  = mem_rdata;
  end

  // Memory command mux; address/data/strobes are zero unless a grant is issued.
  always_comb begin
    mem_en    = w_grant_d || w_grant_i;
    mem_we    = w_grant_d && d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (w_grant_d) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_wstrb = d_wstrb;
    end else if (w_grant_i) begin
      mem_addr  = i_addr;
      mem_wdata = '0;
      mem_wstrb = c_STRB_W'(0);
    end
  end

  // Control FSM: writes complete in the grant cycle; reads wait out the latency.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_prio  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_d || w_grant_i) begin
            // Hand priority to the port that did not win, contended or not.
            r_prio <= w_grant_d;
            if (w_grant_i || !d_we) begin
              r_owner <= w_grant_i;
              r_cnt   <= c_CNT_W'(MEM_LATENCY);
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - c_CNT_W'(1);
          if (r_cnt == c_CNT_W'(1)) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
